// File: rtl/ir_pkg.sv
// Shared loader/instruction-memory definitions.
// FSM encoding, word geometry and the address-width helper.
package ir_pkg;

  localparam int DEF_LENGTH = 16;
  localparam int BYTES_PER_WORD = DEF_LENGTH / 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_HDR    = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_WRITE  = 3'd3;
  localparam state_t S_FINISH = 3'd4;

  function automatic int log2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Shifts bytes MSB-first into a word; flags the word-completing byte.
// Ports: clk, reset_n, clr, shift_en, byte_data -> word_next, word_valid.
module byte_packer #(
  parameter int LENGTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_data,
  output logic [LENGTH-1:0] word_next,
  output logic              word_valid
);

  localparam int BPW = LENGTH / 8;

  logic [LENGTH-1:0] word;
  logic [7:0]        cnt;

  assign word_next  = LENGTH'({word, byte_data});
  assign word_valid = shift_en && (cnt == 8'(BPW - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      word <= word_next;
      cnt  <= word_valid ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream loader: header N, then N words written to addr 0..N-1.
// Ports: byte valid/ready in, ext_we/addr/data write port, busy/done/error.
module program_loader
  import ir_pkg::*;
#(
  parameter int LENGTH   = 16,
  parameter int IR_DEPTH = 32,
  localparam int AW = (log2(IR_DEPTH) < 1) ? 1 : log2(IR_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              ext_we,
  output logic              test_normal,
  output logic [AW-1:0]     ext_addr,
  output logic [LENGTH-1:0] ext_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state, nxt;
  logic [8:0]        n_words;
  logic [AW-1:0]     widx;
  logic              acc;
  logic              hdr_ok;
  logic              last_word;
  logic              pk_clr;
  logic              pk_shift;
  logic              word_valid;
  logic [LENGTH-1:0] word_next;

  assign acc       = byte_valid & byte_ready;
  assign hdr_ok    = (byte_data != 8'd0) &&
                     ({1'b0, byte_data} <= 9'(IR_DEPTH));
  // 9-bit compare so N == IR_DEPTH ends at IR_DEPTH-1 without wrap
  assign last_word = (9'(widx) + 9'd1) == n_words;
  assign pk_clr    = (state == S_HDR) && acc;
  assign pk_shift  = (state == S_DATA) && acc;

  byte_packer #(.LENGTH(LENGTH)) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (pk_clr),
    .shift_en   (pk_shift),
    .byte_data  (byte_data),
    .word_next  (word_next),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (start) nxt = S_HDR;
      S_HDR:    if (acc) nxt = hdr_ok ? S_DATA : S_FINISH;
      S_DATA:   if (word_valid) nxt = S_WRITE;
      S_WRITE:  nxt = last_word ? S_FINISH : S_DATA;
      S_FINISH: nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready  = 1'b0;
    ext_we      = 1'b0;
    busy        = 1'b0;
    test_normal = 1'b0;
    if (state == S_HDR || state == S_DATA) byte_ready = 1'b1;
    if (state == S_WRITE) ext_we = 1'b1;
    if (state != S_IDLE) begin
      busy        = 1'b1;
      test_normal = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_words  <= '0;
      widx     <= '0;
      ext_addr <= '0;
      ext_data <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          done  <= 1'b0;
          error <= 1'b0;
        end
        S_HDR: if (acc) begin
          if (hdr_ok) begin
            n_words <= {1'b0, byte_data};
            widx    <= '0;
          end else begin
            error <= 1'b1;
          end
        end
        // capture on entry so the write port is stable all of WRITE
        S_DATA: if (word_valid) begin
          ext_data <= word_next;
          ext_addr <= widx;
        end
        S_WRITE:  if (!last_word) widx <= widx + 1'b1;
        S_FINISH: if (!error) done <= 1'b1;
        default:  ;
      endcase
    end
  end

endmodule
